// File: rtl/error_tracker_if.sv
// Bundle of control strobes and status outputs exchanged between the
// per-lane reaction checkers / game-control FSM and the error tracker.
interface error_tracker_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 2
);
    logic                      clear;
    logic [CHANNELS-1:0]       inc;
    logic [CHANNELS-1:0]       dec;
    logic [CHANNELS*WIDTH-1:0] error_count;
    logic [CHANNELS-1:0]       limit_reached;
    logic [CHANNELS-1:0]       limit_pulse;
    logic                      all_out;

    // Producer of error/forgive strobes, consumer of counts and flags.
    modport master (
        output clear, inc, dec,
        input  error_count, limit_reached, limit_pulse, all_out
    );

    // The tracker itself.
    modport slave (
        input  clear, inc, dec,
        output error_count, limit_reached, limit_pulse, all_out
    );
endinterface

// File: rtl/error_tracker.sv
// Multi-channel saturating error counter: counts rising edges of inc per
// channel, forgives on dec, optionally decays after a run of idle cycles,
// and flags lock-out when a channel reaches MAX_ERRORS.
module error_tracker #(
    parameter int CHANNELS     = 2,
    parameter int WIDTH        = 2,
    parameter int MAX_ERRORS   = 3,
    parameter int DECAY_CYCLES = 0
) (
    input  logic            ck,
    input  logic            reset,
    error_tracker_if.slave  bus
);
    localparam int               IDLE_W    = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_ERRORS);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((DECAY_CYCLES > 0) ? DECAY_CYCLES - 1 : 0);
    localparam bit               DECAY_EN  = (DECAY_CYCLES > 0);

    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [WIDTH-1:0]    count_d [CHANNELS];
    logic [IDLE_W-1:0]   idle_q  [CHANNELS];
    logic [IDLE_W-1:0]   idle_d  [CHANNELS];
    logic [CHANNELS-1:0] inc_prev_q;
    logic [CHANNELS-1:0] inc_ev;
    logic [CHANNELS-1:0] limit_pulse_q;
    logic [CHANNELS-1:0] limit_pulse_d;
    logic [CHANNELS-1:0] limit_reached;

    // A held inc level is counted once, on its rising edge only.
    assign inc_ev = bus.inc & ~inc_prev_q;

    // Per-channel next count/idle in priority order: clear, inc+dec cancel,
    // inc, dec, decay, hold.
    always_comb begin
        count_d       = count_q;
        idle_d        = '{default: '0};
        limit_pulse_d = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (bus.clear) begin
                count_d[c] = '0;
            end else if (inc_ev[c] && bus.dec[c]) begin
                count_d[c] = count_q[c];
            end else if (inc_ev[c]) begin
                if (count_q[c] < MAX_V) count_d[c] = count_q[c] + 1'b1;
            end else if (bus.dec[c]) begin
                if (count_q[c] != '0) count_d[c] = count_q[c] - 1'b1;
            end else if (DECAY_EN && (count_q[c] != '0) && (count_q[c] != MAX_V)) begin
                if (idle_q[c] == IDLE_LAST) begin
                    count_d[c] = count_q[c] - 1'b1;
                end else begin
                    idle_d[c] = idle_q[c] + 1'b1;
                end
            end
            limit_pulse_d[c] = !bus.clear && (count_d[c] == MAX_V) && (count_q[c] != MAX_V);
        end
    end

    // State registers; inc_prev keeps tracking through clear so a held inc
    // is not recounted afterwards.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            count_q       <= '{default: '0};
            idle_q        <= '{default: '0};
            inc_prev_q    <= '0;
            limit_pulse_q <= '0;
        end else begin
            count_q       <= count_d;
            idle_q        <= idle_d;
            inc_prev_q    <= bus.inc;
            limit_pulse_q <= limit_pulse_d;
        end
    end

    // Status outputs derived from the registered counts.
    always_comb begin
        bus.error_count = '0;
        limit_reached   = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            bus.error_count[c*WIDTH +: WIDTH] = count_q[c];
            limit_reached[c]                  = (count_q[c] == MAX_V);
        end
    end

    assign bus.limit_reached = limit_reached;
    assign bus.limit_pulse   = limit_pulse_q;
    assign bus.all_out       = &limit_reached;
endmodule
